// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB)
// with fetch/data-memory wait states, per-wait timeout, illegal-opcode trap and optional RV64 word ops.
module unidad_control_multiciclo #(
  parameter int ANCHO_INSTR = 32,
  parameter int TIMEOUT_MAX = 15,
  parameter bit MODO_RV64   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ANCHO_INSTR-1:0] Instruccion,
  input  logic                   instr_valida,
  input  logic                   mem_listo,
  output logic                   IR_WR,
  output logic                   PC_WR,
  output logic                   salto,
  output logic [1:0]             S_Mux_B,
  output logic [1:0]             S_Mux_C,
  output logic                   REG_RD,
  output logic                   REG_WR,
  output logic                   MEM_RD,
  output logic                   MEM_WR,
  output logic                   trap,
  output logic [1:0]             causa,
  output logic [2:0]             estado
);

  localparam int CW = (TIMEOUT_MAX > 0) ? (($clog2(TIMEOUT_MAX + 1) > 0) ? $clog2(TIMEOUT_MAX + 1) : 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = (TIMEOUT_MAX > 0) ? CW'(TIMEOUT_MAX - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_MAX > 0);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } estado_e;

  typedef enum logic [2:0] {
    CL_ILEGAL, CL_R, CL_I, CL_LUI, CL_LOAD, CL_STORE, CL_BRANCH
  } clase_e;

  estado_e       estado_q, estado_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    causa_q, causa_d;
  clase_e        clase;
  logic [1:0]    mux_b_clase;

  logic instr_unused;
  assign instr_unused = ^Instruccion[ANCHO_INSTR-1:7];

  always_comb begin
    clase = CL_ILEGAL;
    case (opcode_q)
      7'b0110011: clase = CL_R;
      7'b0010011: clase = CL_I;
      7'b0111011: clase = MODO_RV64 ? CL_R : CL_ILEGAL;
      7'b0011011: clase = MODO_RV64 ? CL_I : CL_ILEGAL;
      7'b0110111: clase = CL_LUI;
      7'b0000011: clase = CL_LOAD;
      7'b0100011: clase = CL_STORE;
      7'b1100011: clase = CL_BRANCH;
      default:    clase = CL_ILEGAL;
    endcase
  end

  always_comb begin
    mux_b_clase = 2'b00;
    case (clase)
      CL_I, CL_LOAD:     mux_b_clase = 2'b01;
      CL_STORE:          mux_b_clase = 2'b10;
      CL_LUI, CL_BRANCH: mux_b_clase = 2'b11;
      default:           mux_b_clase = 2'b00;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    opcode_d = opcode_q;
    cnt_d    = '0;
    causa_d  = causa_q;
    IR_WR    = 1'b0;
    PC_WR    = 1'b0;
    salto    = 1'b0;
    S_Mux_B  = 2'b00;
    S_Mux_C  = 2'b11;
    REG_RD   = 1'b0;
    REG_WR   = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    case (estado_q)
      FETCH: begin
        IR_WR = instr_valida & ~rst;
        if (instr_valida) begin
          opcode_d = Instruccion[6:0];
          estado_d = DECODE;
        end else if (TO_EN && cnt_q == CNT_LIM) begin
          estado_d = TRAP;
          causa_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        REG_RD = (clase != CL_ILEGAL) && (clase != CL_LUI);
        if (clase == CL_ILEGAL) begin
          estado_d = TRAP;
          causa_d  = 2'b01;
        end else begin
          estado_d = EXEC;
        end
      end
      EXEC: begin
        S_Mux_B = mux_b_clase;
        if (clase == CL_BRANCH) begin
          salto    = 1'b1;
          PC_WR    = 1'b1;
          estado_d = FETCH;
        end else if (clase == CL_LOAD || clase == CL_STORE) begin
          estado_d = MEM;
        end else begin
          estado_d = WB;
        end
      end
      MEM: begin
        S_Mux_B = mux_b_clase;
        MEM_RD  = (clase == CL_LOAD);
        MEM_WR  = (clase == CL_STORE);
        // A store retires on its ack cycle, so its single PC_WR pulse follows mem_listo.
        if (mem_listo) begin
          if (clase == CL_LOAD) begin
            estado_d = WB;
          end else begin
            PC_WR    = 1'b1;
            estado_d = FETCH;
          end
        end else if (TO_EN && cnt_q == CNT_LIM) begin
          estado_d = TRAP;
          causa_d  = 2'b11;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB: begin
        S_Mux_B  = mux_b_clase;
        REG_WR   = 1'b1;
        PC_WR    = 1'b1;
        case (clase)
          CL_LUI:  S_Mux_C = 2'b00;
          CL_LOAD: S_Mux_C = 2'b10;
          default: S_Mux_C = 2'b01;
        endcase
        estado_d = FETCH;
      end
      TRAP: begin
        estado_d = TRAP;
      end
      default: begin
        estado_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= FETCH;
      opcode_q <= 7'd0;
      cnt_q    <= '0;
      causa_q  <= 2'b00;
    end else begin
      estado_q <= estado_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      causa_q  <= causa_d;
    end
  end

  assign trap   = (estado_q == TRAP);
  assign causa  = causa_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - randomized bench for unidad_control_multiciclo; expected
// per-cycle traces are built from instruction class, wait counts and the timeout rule.
module tb_unidad_control_multiciclo;

  logic              clk = 1'b0;
  logic [1:0]        rst, iv, ml;
  logic [31:0]       instr [2];
  logic [1:0]        ir_wr, pc_wr, salto, reg_rd, reg_wr, mem_rd, mem_wr, trp;
  logic [1:0]        smb [2];
  logic [1:0]        smc [2];
  logic [1:0]        causa [2];
  logic [2:0]        est [2];
  int                n_vec = 0;
  int                n_err = 0;

  localparam logic [31:0] W_ADDI  = 32'h00500093;
  localparam logic [31:0] W_LOAD  = 32'h0000A103;
  localparam logic [31:0] W_STORE = 32'h0020A023;
  localparam logic [31:0] W_ADDW  = 32'h002081BB;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.ANCHO_INSTR(32), .TIMEOUT_MAX(4), .MODO_RV64(1'b0)) dut_a (
    .clk(clk), .rst(rst[0]), .Instruccion(instr[0]), .instr_valida(iv[0]), .mem_listo(ml[0]),
    .IR_WR(ir_wr[0]), .PC_WR(pc_wr[0]), .salto(salto[0]), .S_Mux_B(smb[0]), .S_Mux_C(smc[0]),
    .REG_RD(reg_rd[0]), .REG_WR(reg_wr[0]), .MEM_RD(mem_rd[0]), .MEM_WR(mem_wr[0]),
    .trap(trp[0]), .causa(causa[0]), .estado(est[0]));

  unidad_control_multiciclo #(.ANCHO_INSTR(32), .TIMEOUT_MAX(15), .MODO_RV64(1'b1)) dut_b (
    .clk(clk), .rst(rst[1]), .Instruccion(instr[1]), .instr_valida(iv[1]), .mem_listo(ml[1]),
    .IR_WR(ir_wr[1]), .PC_WR(pc_wr[1]), .salto(salto[1]), .S_Mux_B(smb[1]), .S_Mux_C(smc[1]),
    .REG_RD(reg_rd[1]), .REG_WR(reg_wr[1]), .MEM_RD(mem_rd[1]), .MEM_WR(mem_wr[1]),
    .trap(trp[1]), .causa(causa[1]), .estado(est[1]));

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%05h exp=%05h (ir pc sal mb mc rrd rwr mrd mwr trap causa est)",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic ir, input logic pc, input logic sal,
                                     input logic [1:0] mb, input logic [1:0] mc,
                                     input logic rrd, input logic rwr, input logic mrd,
                                     input logic mwr, input logic tr, input logic [1:0] cz,
                                     input logic [2:0] e);
    return {ir, pc, sal, mb, mc, rrd, rwr, mrd, mwr, tr, cz, e};
  endfunction

  function automatic logic [16:0] obs(input int s);
    return {ir_wr[s], pc_wr[s], salto[s], smb[s], smc[s], reg_rd[s], reg_wr[s],
            mem_rd[s], mem_wr[s], trp[s], causa[s], est[s]};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // 0 illegal, 1 R, 2 I, 3 LUI, 4 LOAD, 5 STORE, 6 BRANCH
  function automatic int classify(input logic [6:0] op, input bit rv64);
    case (op)
      7'h33: return 1;
      7'h13: return 2;
      7'h3B: return rv64 ? 1 : 0;
      7'h1B: return rv64 ? 2 : 0;
      7'h37: return 3;
      7'h03: return 4;
      7'h23: return 5;
      7'h63: return 6;
      default: return 0;
    endcase
  endfunction

  // Called at a falling edge: drive, check, then advance to the next falling edge.
  task automatic cyc(input int s, input logic v, input logic m, input logic [31:0] w,
                     input logic [16:0] e, input string tag);
    iv[s] = v;
    ml[s] = m;
    instr[s] = w;
    #1 check(tag, obs(s), e);
    @(negedge clk);
  endtask

  task automatic reset_dut(input int s);
    rst[s] = 1'b1;
    iv[s] = 1'b1;
    ml[s] = 1'b1;
    #1 check("reset", obs(s), mk(0, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0));
    @(negedge clk);
    #1 check("reset_hold", obs(s), mk(0, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0));
    @(negedge clk);
    rst[s] = 1'b0;
  endtask

  task automatic run_instr(input int s, input logic [31:0] w, input int wf, input int wm);
    int tmax, cls;
    logic [1:0] mb, mc, cz;
    logic done, a;
    tmax = (s == 1) ? 15 : 4;
    cls = classify(w[6:0], s == 1);
    case (cls)
      2, 4: mb = 2'd1;
      5:    mb = 2'd2;
      3, 6: mb = 2'd3;
      default: mb = 2'd0;
    endcase
    mc = (cls == 3) ? 2'd0 : (cls == 4) ? 2'd2 : 2'd1;
    cz = 2'd0;
    done = 1'b0;
    for (int k = 0; k <= wf; k++) begin
      if (k >= tmax) begin
        cz = 2'd2;
        break;
      end
      a = (k == wf);
      cyc(s, a, rb(), a ? w : $urandom, mk(a, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0), "fetch");
    end
    if (cz == 2'd0) begin
      cyc(s, rb(), rb(), $urandom,
          mk(0, 0, 0, 2'd0, 2'd3, (cls != 0) && (cls != 3), 0, 0, 0, 0, 2'd0, 3'd1), "decode");
      if (cls == 0) cz = 2'd1;
    end
    if (cz == 2'd0) begin
      cyc(s, rb(), rb(), $urandom, mk(0, cls == 6, cls == 6, mb, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd2), "exec");
      if (cls == 6) done = 1'b1;
    end
    if (cz == 2'd0 && !done && (cls == 4 || cls == 5)) begin
      for (int k = 0; k <= wm; k++) begin
        if (k >= tmax) begin
          cz = 2'd3;
          break;
        end
        a = (k == wm);
        cyc(s, rb(), a, $urandom,
            mk(0, (cls == 5) && a, 0, mb, 2'd3, 0, 0, cls == 4, cls == 5, 0, 2'd0, 3'd3), "mem");
      end
      if (cz == 2'd0 && cls == 5) done = 1'b1;
    end
    if (cz == 2'd0 && !done)
      cyc(s, rb(), rb(), $urandom, mk(0, 1, 0, mb, mc, 0, 1, 0, 0, 0, 2'd0, 3'd4), "wb");
    if (cz != 2'd0) begin
      repeat (2) cyc(s, rb(), rb(), $urandom, mk(0, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 1, cz, 3'd7), "trap");
      reset_dut(s);
    end
  endtask

  task automatic run_random(input int s, input int n);
    logic [6:0] ops [8];
    logic [31:0] w;
    int tmax, wf, wm;
    ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h3B, 7'h1B};
    tmax = (s == 1) ? 15 : 4;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 7)];
      wf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tmax + 1) : $urandom_range(0, 1);
      wm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tmax + 1) : $urandom_range(0, 1);
      run_instr(s, w, wf, wm);
    end
  endtask

  initial begin
    rst = 2'b11;
    iv = 2'b00;
    ml = 2'b00;
    instr[0] = '0;
    instr[1] = '0;
    @(negedge clk);

    reset_dut(0);
    run_instr(0, W_ADDI, 0, 0);
    run_instr(0, W_LOAD, 0, 3);
    run_instr(0, W_STORE, 0, 0);
    run_instr(0, W_ADDW, 0, 0);
    run_instr(0, W_ADDI, 100, 0);
    run_instr(0, W_ADDI, 3, 0);
    run_instr(0, W_LOAD, 1, 10);
    run_instr(0, W_STORE, 2, 3);

    cyc(0, 1, 0, W_STORE, mk(1, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0), "ab_fetch");
    cyc(0, 0, 0, $urandom, mk(0, 0, 0, 2'd0, 2'd3, 1, 0, 0, 0, 0, 2'd0, 3'd1), "ab_decode");
    cyc(0, 0, 0, $urandom, mk(0, 0, 0, 2'd2, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd2), "ab_exec");
    iv[0] = 1'b0;
    ml[0] = 1'b0;
    #1 check("ab_mem", obs(0), mk(0, 0, 0, 2'd2, 2'd3, 0, 0, 0, 1, 0, 2'd0, 3'd3));
    #1 rst[0] = 1'b1;
    #1 check("ab_async", obs(0), mk(0, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0));
    @(negedge clk);
    rst[0] = 1'b0;
    cyc(0, 0, 0, $urandom, mk(0, 0, 0, 2'd0, 2'd3, 0, 0, 0, 0, 0, 2'd0, 3'd0), "ab_post");
    reset_dut(0);

    run_random(0, 300);

    reset_dut(1);
    run_instr(1, W_ADDW, 0, 0);
    run_instr(1, W_LOAD, 2, 14);
    run_instr(1, W_ADDI, 15, 0);
    run_random(1, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
